// File: rtl/multi_pulse_timer.sv
// multi_pulse_timer: NUM_CH independent delayed-pulse generators on one clock.
// Each channel latches delay/width on trigger, waits, drives out for width cycles, then pulses done.
module multi_pulse_timer #(
    parameter int WIDTH           = 24,
    parameter int NUM_CH          = 4,
    parameter int RETRIGGER       = 0,
    parameter int OUT_ACTIVE_HIGH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         trigger,
    input  logic [NUM_CH-1:0]         abort,
    input  logic [NUM_CH*WIDTH-1:0]   delay,
    input  logic [NUM_CH*WIDTH-1:0]   width,
    output logic [NUM_CH-1:0]         out,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_ACTIVE} state_t;

    localparam logic             ACT_LVL = (OUT_ACTIVE_HIGH != 0);
    localparam logic             RETRIG  = (RETRIGGER != 0);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q   [NUM_CH];
    logic [WIDTH-1:0]  cnt_d   [NUM_CH];
    logic [WIDTH-1:0]  d_lat_q [NUM_CH];
    logic [WIDTH-1:0]  d_lat_d [NUM_CH];
    logic [WIDTH-1:0]  w_lat_q [NUM_CH];
    logic [WIDTH-1:0]  w_lat_d [NUM_CH];
    logic [WIDTH-1:0]  delay_ch [NUM_CH];
    logic [WIDTH-1:0]  width_ch [NUM_CH];
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign delay_ch[g] = delay[g*WIDTH +: WIDTH];
        assign width_ch[g] = width[g*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                d_lat_q[i] <= '0;
                w_lat_q[i] <= '0;
            end
            done_q    <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_lat_q   <= d_lat_d;
            w_lat_q   <= w_lat_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Terminal compares stop at latch-1, so the counter can never wrap.
    always_comb begin
        logic fin;
        fin       = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_lat_d   = d_lat_q;
        w_lat_d   = w_lat_q;
        done_d    = '0;
        overrun_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fin = 1'b0;
            case (state_q[i])
                ST_DELAY: begin
                    if (cnt_q[i] == d_lat_q[i] - ONE) begin
                        cnt_d[i] = '0;
                        if (w_lat_q[i] != '0) begin
                            state_d[i] = ST_ACTIVE;
                        end else begin
                            state_d[i] = ST_IDLE;
                            done_d[i]  = 1'b1;
                            fin        = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q[i] == w_lat_q[i] - ONE) begin
                        cnt_d[i]   = '0;
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                        fin        = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                    end
                end
                default: ;
            endcase

            // Abort dominates everything, including a same-edge trigger or completion.
            if (abort[i]) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                done_d[i]  = 1'b0;
            end else if (trigger[i]) begin
                if (state_q[i] == ST_IDLE || RETRIG || fin) begin
                    d_lat_d[i] = delay_ch[i];
                    w_lat_d[i] = width_ch[i];
                    cnt_d[i]   = '0;
                    if (delay_ch[i] != '0) begin
                        state_d[i] = ST_DELAY;
                    end else if (width_ch[i] != '0) begin
                        state_d[i] = ST_ACTIVE;
                    end else begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out  = '0;
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (state_q[i] != ST_IDLE);
            out[i]  = (state_q[i] == ST_ACTIVE) ? ACT_LVL : ~ACT_LVL;
        end
    end

    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_multi_pulse_timer.sv
// Testbench for multi_pulse_timer: two instances (drop/active-low and retrigger/active-high)
// share stimulus and are compared each cycle against a start-time/duration reference model.
module tb_multi_pulse_timer;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0]   trigger = '0;
    logic [N-1:0]   abort = '0;
    logic [N*W-1:0] delay = '0;
    logic [N*W-1:0] width = '0;
    logic [N-1:0]   out_a, busy_a, done_a, ovr_a;
    logic [N-1:0]   out_b, busy_b, done_b, ovr_b;

    int compared = 0;
    int mismatched = 0;
    int edge_n = 0;

    bit           m_busy [2][N];
    int           m_t0   [2][N];
    int           m_d    [2][N];
    int           m_w    [2][N];
    logic [N-1:0] e_done [2];
    logic [N-1:0] e_ovr  [2];

    always #5 clk = ~clk;

    multi_pulse_timer #(.WIDTH(W), .NUM_CH(N), .RETRIGGER(0), .OUT_ACTIVE_HIGH(0)) u_a (
        .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .delay(delay), .width(width),
        .out(out_a), .busy(busy_a), .done(done_a), .overrun(ovr_a));

    multi_pulse_timer #(.WIDTH(W), .NUM_CH(N), .RETRIGGER(1), .OUT_ACTIVE_HIGH(1)) u_b (
        .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .delay(delay), .width(width),
        .out(out_b), .busy(busy_b), .done(done_b), .overrun(ovr_b));

    // Reference: a pulse accepted at edge t0 is active over edges [t0+D, t0+D+W) and ends at t0+D+W.
    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            e_done[k] = '0;
            e_ovr[k]  = '0;
            for (int c = 0; c < N; c++) m_busy[k][c] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                e_done[k][c] = 1'b0;
                e_ovr[k][c]  = 1'b0;
                if (reset) begin
                    m_busy[k][c] = 1'b0;
                end else begin
                    if (m_busy[k][c] && edge_n == m_t0[k][c] + m_d[k][c] + m_w[k][c]) begin
                        m_busy[k][c] = 1'b0;
                        e_done[k][c] = 1'b1;
                    end
                    if (abort[c]) begin
                        m_busy[k][c] = 1'b0;
                        e_done[k][c] = 1'b0;
                    end else if (trigger[c]) begin
                        if (!m_busy[k][c] || k == 1) begin
                            m_t0[k][c] = edge_n;
                            m_d[k][c]  = int'(delay[c*W +: W]);
                            m_w[k][c]  = int'(width[c*W +: W]);
                            if (m_d[k][c] + m_w[k][c] == 0) begin
                                m_busy[k][c] = 1'b0;
                                e_done[k][c] = 1'b1;
                            end else begin
                                m_busy[k][c] = 1'b1;
                            end
                        end else begin
                            e_ovr[k][c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [8*N-1:0] exp_vec();
        logic [N-1:0] o [2];
        logic [N-1:0] b [2];
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                logic act;
                act     = m_busy[k][c] && (edge_n >= m_t0[k][c] + m_d[k][c]);
                b[k][c] = m_busy[k][c];
                o[k][c] = (k == 1) ? act : ~act;
            end
        end
        return {o[0], b[0], e_done[0], e_ovr[0], o[1], b[1], e_done[1], e_ovr[1]};
    endfunction

    function automatic logic [8*N-1:0] act_vec();
        return {out_a, busy_a, done_a, ovr_a, out_b, busy_b, done_b, ovr_b};
    endfunction

    task automatic load(input int c, input logic [W-1:0] d, input logic [W-1:0] w);
        delay[c*W +: W] = d;
        width[c*W +: W] = w;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        edge_n++;
        model_update();
        #1;
        trigger = '0;
        abort   = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec())
                $display("[TB] FAIL reset_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            if (act_vec() !== exp_vec()) mismatched++;
        end
        compared++;
        if (out_a !== 4'hF || out_b !== 4'h0 || busy_a !== 4'h0 || done_b !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: out_a=%h out_b=%h busy_a=%h done_b=%h, want F 0 0 0",
                     out_a, out_b, busy_a, done_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int e0;
        load(0, 8'd3, 8'd2);
        trigger[0] = 1'b1;
        e0 = edge_n + 1;
        for (int i = 0; i < 8; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL basic_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == e0 + 3 || edge_n == e0 + 5) begin
                compared++;
                if (out_b[0] !== (edge_n == e0 + 3) || done_b[0] !== (edge_n == e0 + 5)) begin
                    mismatched++;
                    $display("[TB] FAIL basic_timing edge %0d: out=%b done=%b", edge_n, out_b[0], done_b[0]);
                end
            end
        end
    endtask

    task automatic test_zero_lengths();
        load(0, 8'd0, 8'd1);
        load(1, 8'd0, 8'd0);
        load(2, 8'd5, 8'd0);
        trigger = 4'b0111;
        for (int i = 0; i < 9; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL zero_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (i == 0) begin
                compared++;
                if (done_b[1] !== 1'b1 || busy_b[1] !== 1'b0 || out_b[0] !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL zero_d0w0: done=%b busy=%b out0=%b, want 1 0 1",
                             done_b[1], busy_b[1], out_b[0]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int e0;
        load(1, 8'd4, 8'd4);
        e0 = edge_n + 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || i == 6 || i == 8) trigger[1] = 1'b1;
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL overrun_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == e0 + 6 || edge_n == e0 + 8) begin
                compared++;
                if (ovr_a[1] !== (edge_n == e0 + 6) || done_a[1] !== (edge_n == e0 + 8)) begin
                    mismatched++;
                    $display("[TB] FAIL overrun_flags edge %0d: ovr=%b done=%b", edge_n, ovr_a[1], done_a[1]);
                end
            end
        end
    endtask

    task automatic test_retrigger();
        int e0;
        load(2, 8'd4, 8'd4);
        e0 = edge_n + 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) trigger[2] = 1'b1;
            if (i == 6) begin
                load(2, 8'd2, 8'd3);
                trigger[2] = 1'b1;
            end
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL retrig_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == e0 + 6 || edge_n == e0 + 8 || edge_n == e0 + 11) begin
                compared++;
                if (out_b[2] !== (edge_n == e0 + 8) || done_b[2] !== (edge_n == e0 + 11)) begin
                    mismatched++;
                    $display("[TB] FAIL retrig_timing edge %0d: out=%b done=%b", edge_n, out_b[2], done_b[2]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int e0;
        load(1, 8'd2, 8'd10);
        e0 = edge_n + 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) trigger[1] = 1'b1;
            if (i == 5) abort[1] = 1'b1;
            if (i == 10) begin
                trigger[3] = 1'b1;
                abort[3]   = 1'b1;
            end
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL abort_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == e0 + 5 || edge_n == e0 + 10) begin
                compared++;
                if (out_b[1] !== 1'b0 || busy_b[1] !== 1'b0 || busy_a[3] !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL abort_state edge %0d: out=%b busy=%b busy3=%b, want 0 0 0",
                             edge_n, out_b[1], busy_b[1], busy_a[3]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        load(0, 8'd1, 8'd5);
        trigger[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL areset_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
        end
        reset = 1'b1;
        #2;
        model_clear();
        compared++;
        if (out_a[0] !== 1'b1 || out_b[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL areset_immediate: out_a=%b out_b=%b busy_b=%b, want 1 0 0",
                     out_a[0], out_b[0], busy_b[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL areset_after edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_long_channels();
        int e0;
        load(0, 8'd10, 8'd20);
        load(1, 8'd0, 8'd7);
        load(2, 8'd100, 8'd1);
        load(3, 8'd255, 8'd255);
        trigger = 4'b1111;
        e0 = edge_n + 1;
        for (int i = 0; i < 515; i++) begin
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL long_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
            if (edge_n == e0 + 254 || edge_n == e0 + 255 || edge_n == e0 + 510) begin
                compared++;
                if (out_a[3] !== (edge_n != e0 + 255) || done_a[3] !== (edge_n == e0 + 510)) begin
                    mismatched++;
                    $display("[TB] FAIL long_ch3 edge %0d: out_a=%b done_a=%b", edge_n, out_a[3], done_a[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) begin
                load(c, W'($urandom_range(0, 6)), W'($urandom_range(0, 6)));
                if ($urandom_range(0, 5) == 0) trigger[c] = 1'b1;
                if ($urandom_range(0, 39) == 0) abort[c] = 1'b1;
            end
            clock_edge();
            compared++;
            if (act_vec() !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL random_vec edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_zero_lengths();
        test_overrun();
        test_retrigger();
        test_abort();
        test_async_reset();
        test_long_channels();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
